// File: rtl/keypad_code_entry_if.sv
// Keypad entry bus: raw decoder input, consumer ack, and the assembled code/key event outputs.
interface keypad_code_entry_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [3:0]              dec_in;
  logic                    code_ack;
  logic [4*NUM_DIGITS-1:0] entered_code;
  logic [2:0]              digit_count;
  logic                    code_entered;
  logic                    key_strobe;
  logic [3:0]              key_value;

  modport master (
    output dec_in, code_ack,
    input  entered_code, digit_count, code_entered, key_strobe, key_value
  );

  modport slave (
    input  dec_in, code_ack,
    output entered_code, digit_count, code_entered, key_strobe, key_value
  );
endinterface

// File: rtl/keypad_code_entry.sv
// Debounces the keypad decoder output into single key events and assembles them into a code.
// Optional inactivity timeout of partial entries is enabled with KEYPAD_TIMEOUT_EN.
//
// state        | meaning
// S_IDLE       | no key seen, waiting for dec_q != F
// S_DB_PRESS   | candidate key must stay stable for DEBOUNCE_CYCLES
// S_HELD       | key accepted and strobed, waiting for release
// S_DB_RELEASE | release must stay stable for DEBOUNCE_CYCLES
module keypad_code_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_DIGITS      = 4,
  parameter logic [3:0]  BKSP_KEY        = 4'hD,
  parameter logic [3:0]  CLR_KEY         = 4'hE,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input logic                clock_100Mhz,
  input logic                reset,
  keypad_code_entry_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DB_PRESS, S_HELD, S_DB_RELEASE} key_state_e;

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned    BW       = 4 * NUM_DIGITS;
  localparam logic [2:0]     FULL_CNT = 3'(NUM_DIGITS);
  localparam logic [3:0]     NO_KEY   = 4'hF;

  if (DEBOUNCE_CYCLES < 2 || NUM_DIGITS < 1 || NUM_DIGITS > 7 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("keypad_code_entry: illegal parameter value");
  end

  key_state_e    state_q, state_d;
  logic [3:0]    dec_q;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;
  logic [3:0]    key_q, key_d;
  logic [BW-1:0] code_q, code_d;
  logic [2:0]    count_q, count_d;
  logic          full_q, full_d;
  logic [BW-1:0] key_ext;
  logic          tmo_fire;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      dec_q    <= NO_KEY;
      cand_q   <= NO_KEY;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      key_q    <= NO_KEY;
      code_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dec_q    <= bus.dec_in;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      key_q    <= key_d;
      code_q   <= code_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    key_d    = key_q;
    unique case (state_q)
      S_IDLE: begin
        if (dec_q != NO_KEY) begin
          cand_d  = dec_q;
          cnt_d   = '0;
          state_d = S_DB_PRESS;
        end
      end
      S_DB_PRESS: begin
        if (dec_q == NO_KEY) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (dec_q != cand_q) begin
          cand_d = dec_q;
          cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
          strobe_d = 1'b1;
          key_d    = cand_q;
          cnt_d    = '0;
          state_d  = S_HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        // Other keys are ignored until a clean release.
        if (dec_q == NO_KEY) begin
          cnt_d   = '0;
          state_d = S_DB_RELEASE;
        end
      end
      S_DB_RELEASE: begin
        if (dec_q != NO_KEY) begin
          state_d = S_HELD;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef KEYPAD_TIMEOUT_EN
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  always_comb begin
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if (!strobe_q && count_q != 3'd0 && count_q < FULL_CNT) begin
      if (tmo_q == TMO_LAST) tmo_fire = 1'b1;
      else                   tmo_d    = tmo_q + 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    key_ext      = '0;
    key_ext[3:0] = key_q;
  end

  always_comb begin
    code_d  = code_q;
    count_d = count_q;
    full_d  = full_q;
    // An ack on the same edge as a key update wins; the key event is dropped.
    if (full_q && bus.code_ack) begin
      code_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
    end else if (strobe_q) begin
      if (key_q == CLR_KEY) begin
        code_d  = '0;
        count_d = '0;
        full_d  = 1'b0;
      end else if (key_q == BKSP_KEY) begin
        if (count_q != 3'd0) begin
          code_d  = code_q >> 4;
          count_d = count_q - 1'b1;
          full_d  = 1'b0;
        end
      end else if (!full_q) begin
        code_d  = (code_q << 4) | key_ext;
        count_d = count_q + 1'b1;
        full_d  = ((count_q + 1'b1) == FULL_CNT);
      end
    end else if (tmo_fire) begin
      code_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
    end
  end

  assign bus.entered_code = code_q;
  assign bus.digit_count  = count_q;
  assign bus.code_entered = full_q;
  assign bus.key_strobe   = strobe_q;
  assign bus.key_value    = key_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Self-checking bench for keypad_code_entry against a queue-based model of the entry rules.
module tb_keypad_code_entry;
  localparam int         DB   = 4;
  localparam int         ND   = 4;
  localparam int         TMO  = 20;
  localparam logic [3:0] BKSP = 4'hD;
  localparam logic [3:0] CLR  = 4'hE;
`ifdef KEYPAD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_code_entry_if #(.NUM_DIGITS(ND)) bus();

  keypad_code_entry #(
    .DEBOUNCE_CYCLES(DB),
    .NUM_DIGITS(ND),
    .BKSP_KEY(BKSP),
    .CLR_KEY(CLR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock_100Mhz(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int digits[$];
  bit m_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_code();
    int v = 0;
    foreach (digits[i]) v = v * 16 + digits[i];
    return 32'(v);
  endfunction

  task automatic m_clear();
    digits.delete();
    m_full = 1'b0;
  endtask

  task automatic m_key(input logic [3:0] k, input bit ack);
    if (ack && m_full) m_clear();
    else if (k == CLR) m_clear();
    else if (k == BKSP) begin
      if (digits.size() > 0) begin
        void'(digits.pop_back());
        m_full = 1'b0;
      end
    end else if (!m_full) begin
      digits.push_back(int'(k));
      m_full = (digits.size() == ND);
    end
  endtask

  task automatic check_entry(input string tag);
    check({tag, ".code"},  32'(bus.entered_code), m_code());
    check({tag, ".count"}, 32'(bus.digit_count),  32'(digits.size()));
    check({tag, ".full"},  32'(bus.code_entered), 32'(m_full));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".code"},   32'(bus.entered_code), 32'd0);
    check({tag, ".count"},  32'(bus.digit_count),  32'd0);
    check({tag, ".full"},   32'(bus.code_entered), 32'd0);
    check({tag, ".strobe"}, 32'(bus.key_strobe),   32'd0);
    check({tag, ".kval"},   32'(bus.key_value),    32'hF);
  endtask

  // One press: bounce pairs, steady hold, release bounce pairs, then a long clean release.
  task automatic press(input logic [3:0] k, input int bounce, input int hold, input int relb,
                       input bit ack_on_strobe, output int n_str, output int lat, output logic [3:0] kv);
    logic [3:0] seq[$];
    int first_steady;
    n_str = 0;
    lat   = -1;
    kv    = 4'hF;
    for (int i = 0; i < bounce; i++) begin
      seq.push_back(k);
      seq.push_back(4'hF);
    end
    first_steady = seq.size();
    for (int i = 0; i < hold; i++) seq.push_back(k);
    for (int i = 0; i < relb; i++) begin
      seq.push_back(4'hF);
      seq.push_back(k);
    end
    for (int i = 0; i < DB + 4; i++) seq.push_back(4'hF);
    foreach (seq[i]) begin
      bus.dec_in = seq[i];
      @(posedge clk);
      #1;
      bus.code_ack = 1'b0;
      if (bus.key_strobe === 1'b1) begin
        n_str++;
        kv = bus.key_value;
        if (lat < 0) lat = i - first_steady;
        if (ack_on_strobe) bus.code_ack = 1'b1;
      end
    end
  endtask

  task automatic do_press(input string tag, input logic [3:0] k, input int bounce, input int hold,
                          input int relb, input bit ack);
    int n_str, lat;
    logic [3:0] kv;
    press(k, bounce, hold, relb, ack, n_str, lat, kv);
    check({tag, ".strobes"}, 32'(n_str), 32'd1);
    check({tag, ".kval"},    32'(kv),    32'(k));
    // First stable raw sample to strobe is DEBOUNCE_CYCLES+1 cycles.
    check({tag, ".latency"}, 32'(lat),   32'(DB + 1));
    m_key(k, ack);
    check_entry(tag);
  endtask

  task automatic pulse_ack(input string tag);
    bus.code_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.code_ack = 1'b0;
    if (m_full) m_clear();
    check_entry(tag);
  endtask

  task automatic idle(input int n, output int n_str);
    n_str = 0;
    for (int i = 0; i < n; i++) begin
      bus.dec_in = 4'hF;
      @(posedge clk);
      #1;
      if (bus.key_strobe === 1'b1) n_str++;
    end
  endtask

  initial begin
    int n_idle_str;
    logic [3:0] rk;
    int rsel, rb, rh, rr;
    bit ra;

    bus.dec_in   = 4'hF;
    bus.code_ack = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_press("bounce3", 4'h3, 2, 6, 0, 1'b0);
    do_press("clr0", CLR, 0, 6, 2, 1'b0);

`ifndef KEYPAD_TIMEOUT_EN
    do_press("hold5", 4'h5, 0, 50, 0, 1'b0);
    do_press("clr1", CLR, 0, 6, 0, 1'b0);
`endif

    do_press("d1", 4'h1, 1, 6, 1, 1'b0);
    do_press("d2", 4'h2, 0, 7, 0, 1'b0);
    do_press("d3", 4'h3, 0, 6, 2, 1'b0);
    do_press("d4", 4'h4, 1, 6, 0, 1'b0);
    check("full1234", 32'(bus.entered_code), 32'h1234);
    do_press("d9_frozen", 4'h9, 0, 6, 0, 1'b0);
    pulse_ack("ack_full");

    do_press("d7", 4'h7, 0, 6, 0, 1'b0);
    do_press("d8", 4'h8, 0, 6, 0, 1'b0);
    do_press("bksp", BKSP, 0, 6, 0, 1'b0);
    check("bksp_code", 32'(bus.entered_code), 32'h0007);
    do_press("clr2", CLR, 0, 6, 0, 1'b0);
    do_press("bksp_empty", BKSP, 0, 6, 0, 1'b0);

    do_press("p5", 4'h5, 0, 6, 0, 1'b0);
    pulse_ack("ack_partial");
    do_press("clr3", CLR, 0, 6, 0, 1'b0);

    do_press("c1", 4'h1, 0, 6, 0, 1'b0);
    do_press("c2", 4'h2, 0, 6, 0, 1'b0);
    do_press("c3", 4'h3, 0, 6, 0, 1'b0);
    do_press("c4", 4'h4, 0, 6, 0, 1'b0);
    do_press("ack_clr_collide", CLR, 0, 6, 0, 1'b1);
    do_press("c5", 4'h5, 0, 6, 0, 1'b0);
    do_press("c6", 4'h6, 0, 6, 0, 1'b0);
    do_press("c7", 4'h7, 0, 6, 0, 1'b0);
    do_press("c8", 4'h8, 0, 6, 0, 1'b0);
    do_press("ack_dig_collide", 4'h9, 0, 6, 0, 1'b1);

    // Reset in the middle of debouncing a press while a partial entry is held.
    do_press("r1", 4'h1, 0, 6, 0, 1'b0);
    bus.dec_in = 4'h9;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    m_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_press("after_reset", 4'h9, 0, 6, 0, 1'b0);
    do_press("clr4", CLR, 0, 6, 0, 1'b0);

    do_press("t6", 4'h6, 0, 6, 0, 1'b0);
    idle(TMO, n_idle_str);
    check("tmo.no_strobe", 32'(n_idle_str), 32'd0);
    if (TMO_EN) m_clear();
    check_entry("tmo_partial");
    do_press("clr5", CLR, 0, 6, 0, 1'b0);
    do_press("f1", 4'h1, 0, 6, 0, 1'b0);
    do_press("f2", 4'h2, 0, 6, 0, 1'b0);
    do_press("f3", 4'h3, 0, 6, 0, 1'b0);
    do_press("f4", 4'h4, 0, 6, 0, 1'b0);
    idle(2 * TMO, n_idle_str);
    check_entry("tmo_full_kept");
    pulse_ack("ack_after_idle");

`ifndef KEYPAD_TIMEOUT_EN
    for (int r = 0; r < 40; r++) begin
      rsel = int'($urandom_range(0, 9));
      if (rsel < 7)      rk = 4'($urandom_range(0, 12));
      else if (rsel < 9) rk = BKSP;
      else               rk = CLR;
      rb = int'($urandom_range(0, 3));
      rh = int'($urandom_range(DB + 2, DB + 12));
      rr = int'($urandom_range(0, 3));
      ra = m_full && ($urandom_range(0, 3) == 0);
      do_press($sformatf("rnd%0d", r), rk, rb, rh, rr, ra);
      if (m_full && $urandom_range(0, 1) == 1) pulse_ack($sformatf("rnd_ack%0d", r));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
